// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the LOAD opcode and the hazard controller FSM states.
// Also provides the source/destination register match helper used by hazard detection.
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } hazard_state_e;

    // A source operand collides only if it is actually read and names the same register.
    function automatic logic reg_match(
        input logic [4:0] src_addr,
        input logic       src_valid,
        input logic [4:0] rd_addr
    );
        return src_valid && (src_addr == rd_addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline (master) and the hazard controller (slave).
// Carries the hazard inputs from decode/EX and the stall/flush controls back.
interface hazard_ctrl_if;

    logic [4:0]  id_rs1_addr;
    logic [4:0]  id_rs2_addr;
    logic        id_rs1_valid;
    logic        id_rs2_valid;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_valid;
    logic [6:0]  ex_opcode;
    logic        ex_mc_start;
    logic        ex_mc_done;
    logic        branch_taken;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        id_ex_hold;
    logic        if_id_flush;
    logic        mc_timeout;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
        output ex_rd_addr, ex_rd_valid, ex_opcode, ex_mc_start, ex_mc_done,
        output branch_taken,
        input  pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, if_id_flush,
        input  mc_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_valid, id_rs2_valid,
        input  ex_rd_addr, ex_rd_valid, ex_opcode, ex_mc_start, ex_mc_done,
        input  branch_taken,
        output pc_stall, if_id_stall, id_ex_bubble, id_ex_hold, if_id_flush,
        output mc_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Wrapping 32-bit counters of stalled cycles and IF/ID flush pulses.
// Only instantiated by hazard_ctrl when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (i_stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (i_flush) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign o_stall_cycles = r_stall_cycles;
    assign o_flush_count  = r_flush_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, multi-cycle hold with timeout.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters (otherwise they read 0).
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MC_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave bus
);

    localparam int               CNT_W     = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [0:0]       S_IDLE    = ST_IDLE;
    localparam logic [0:0]       S_MC_BUSY = ST_MC_BUSY;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic w_load_use;
    logic w_tmo_hit;
    logic w_pc_stall;
    logic w_if_id_stall;
    logic w_id_ex_bubble;
    logic w_id_ex_hold;
    logic w_if_id_flush;
    logic w_mc_timeout;

    // A load writing x0 never produces a usable result, so it cannot create a hazard.
    assign w_load_use = (bus.ex_opcode == OPC_LOAD) && bus.ex_rd_valid &&
                        (bus.ex_rd_addr != 5'd0) &&
                        (reg_match(bus.id_rs1_addr, bus.id_rs1_valid, bus.ex_rd_addr) ||
                         reg_match(bus.id_rs2_addr, bus.id_rs2_valid, bus.ex_rd_addr));

    // Completion in the last allowed cycle takes precedence over the abort.
    assign w_tmo_hit = (r_state == S_MC_BUSY) && (r_tmo_cnt == CNT_LAST) && !bus.ex_mc_done;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_stall     = 1'b0;
        w_if_id_stall  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_id_ex_hold   = 1'b0;
        w_if_id_flush  = 1'b0;
        w_mc_timeout   = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.branch_taken) begin
                w_if_id_flush  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (w_load_use) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_bubble = 1'b1;
            end else if (bus.ex_mc_start) begin
                w_pc_stall     = 1'b1;
                w_if_id_stall  = 1'b1;
                w_id_ex_hold   = 1'b1;
                w_state_nxt    = S_MC_BUSY;
            end
        end else begin
            if (bus.ex_mc_done || w_tmo_hit) begin
                w_mc_timeout = w_tmo_hit;
                w_state_nxt  = S_IDLE;
            end else begin
                w_pc_stall    = 1'b1;
                w_if_id_stall = 1'b1;
                w_id_ex_hold  = 1'b1;
            end
        end
    end

    // The counter is held at zero while idle, so every MC_BUSY entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tmo_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.pc_stall     = w_pc_stall;
    assign bus.if_id_stall  = w_if_id_stall;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.id_ex_hold   = w_id_ex_hold;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.mc_timeout   = w_mc_timeout;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk            (clk),
        .rst            (rst),
        .i_stall        (w_pc_stall),
        .i_flush        (w_if_id_flush),
        .o_stall_cycles (bus.stall_cycles),
        .o_flush_count  (bus.flush_count)
    );
`else
    assign bus.stall_cycles = 32'd0;
    assign bus.flush_count  = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MC_TIMEOUT, default 64, meaning max MC_BUSY cycles before abort (legal >= 2).
REQ-002 The block SHALL have port clk  input  1  clock, rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port id_rs1_addr  input  5  rs1 index of instruction in decode.
REQ-005 The block SHALL have port id_rs2_addr  input  5  rs2 index of instruction in decode.
REQ-006 The block SHALL have port id_rs1_valid  input  1  decode instruction reads rs1.
REQ-007 The block SHALL have port id_rs2_valid  input  1  decode instruction reads rs2.
REQ-008 The block SHALL have port ex_rd_addr  input  5  rd index from ID/EX register output.
REQ-009 The block SHALL have port ex_rd_valid  input  1  EX instruction writes rd.
REQ-010 The block SHALL have port ex_opcode  input  7  opcode from ID/EX register output.
REQ-011 The block SHALL have port ex_mc_start  input  1  EX begins a multi-cycle operation.
REQ-012 The block SHALL have port ex_mc_done  input  1  multi-cycle operation completes this cycle.
REQ-013 The block SHALL have port branch_taken  input  1  EX resolved a taken branch or jump.
REQ-014 The block SHALL have port pc_stall  output  1  hold PC.
REQ-015 The block SHALL have port if_id_stall  output  1  hold IF/ID register.
REQ-016 The block SHALL have port id_ex_bubble  output  1  drive ID/EX stall input, loading a NOP.
REQ-017 The block SHALL have port id_ex_hold  output  1  ID/EX register keeps its contents.
REQ-018 The block SHALL have port if_id_flush  output  1  clear IF/ID to NOP.
REQ-019 The block SHALL have port mc_timeout  output  1  one-cycle abort indication.
REQ-020 The block SHALL have port stall_cycles  output  32  count of cycles with pc_stall high.
REQ-021 The block SHALL have port flush_count  output  32  count of if_id_flush pulses.

Function
REQ-022 The block SHALL compute load_use combinationally as: ex_opcode==OPC_LOAD, ex_rd_valid=1, ex_rd_addr!=0, and (id_rs1_valid=1 with id_rs1_addr==ex_rd_addr, or id_rs2_valid=1 with id_rs2_addr==ex_rd_addr).
REQ-023 The FSM SHALL have two states, IDLE and MC_BUSY.
REQ-024 In IDLE, branch_taken SHALL have highest priority: if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0, same cycle; load_use and ex_mc_start SHALL be ignored that cycle.
REQ-025 In IDLE, load_use without branch_taken SHALL drive pc_stall=1, if_id_stall=1 and id_ex_bubble=1 in the same cycle (one-cycle stall) with no state change.
REQ-026 In IDLE, ex_mc_start without branch_taken SHALL drive pc_stall=1, if_id_stall=1 and id_ex_hold=1 in the same cycle, and the FSM SHALL enter MC_BUSY at the next edge.
REQ-027 In MC_BUSY the block SHALL drive pc_stall=1, if_id_stall=1, id_ex_hold=1, id_ex_bubble=0 and if_id_flush=0; branch_taken and load_use SHALL be ignored.
REQ-028 In MC_BUSY, ex_mc_done=1 SHALL deassert all stall/hold outputs that cycle, and the FSM SHALL return to IDLE at the next edge; ex_mc_done SHALL be ignored in IDLE.
REQ-029 The timeout counter ($clog2(MC_TIMEOUT) bits) SHALL clear on entry to MC_BUSY and increment each MC_BUSY cycle.
REQ-030 On the cycle the counter equals MC_TIMEOUT-1 with ex_mc_done=0, the block SHALL assert mc_timeout for that one cycle, deassert stall/hold, and return to IDLE.
REQ-031 If ex_mc_done and timeout coincide, done SHALL win and mc_timeout SHALL stay 0.
REQ-032 id_ex_hold and id_ex_bubble SHALL never be high together.

Reset
REQ-033 rst SHALL asynchronously force state IDLE, timeout counter 0, stall_cycles 0 and flush_count 0; all combinational outputs then follow IDLE rules.
REQ-034 rst asserted mid-MC_BUSY SHALL abort the operation immediately, with no mc_timeout pulse.

Configuration
REQ-035 With HAZARD_PERF_CNT_EN defined, stall_cycles and flush_count SHALL be 32-bit wrapping counters, incremented at each edge where pc_stall or if_id_flush respectively is 1.
REQ-036 Without HAZARD_PERF_CNT_EN, stall_cycles and flush_count SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-037 OPC_LOAD (7'b0000011) and the FSM state enum SHALL live in shared package pipeline_pkg.
REQ-038 The performance counters SHALL be sub-module hazard_perf_cnt, instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-039 Bench SHALL cover load-use: ex_opcode=0000011, ex_rd=5, id_rs2=5 valid -> pc_stall, if_id_stall and id_ex_bubble high for exactly one cycle.
REQ-040 Bench SHALL cover x0 and non-load cases: same as REQ-039 with ex_rd=0, or with ex_opcode=0110011 -> no stall.
REQ-041 Bench SHALL cover branch priority: branch_taken=1 with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_count becomes 1.
REQ-042 Bench SHALL cover multi-cycle completion: ex_mc_start, then ex_mc_done 5 cycles later -> hold for 5 cycles, outputs low in the done cycle, stall_cycles=5.
REQ-043 Bench SHALL cover timeout: MC_TIMEOUT=8, never done -> mc_timeout pulse on the 8th MC_BUSY cycle, then IDLE; done on that cycle -> no pulse.
